// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered read data,
// registered status flags and sticky error flags.
module fifo_sync #(
  parameter int DEPTH    = 32,
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       write,
  input  logic                       read,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     usedw,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_N = CW'(DEPTH);
  localparam logic [CW-1:0] AF_N   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_N   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] used_nxt;

  logic flush;
  logic rd_acc;
  logic wr_acc;

  assign flush  = reset | clear;
  assign rd_acc = read & ~empty;
  // a full FIFO still takes a write when a read frees a slot
  assign wr_acc = write & (~full | rd_acc);

  always_comb begin
    used_nxt = usedw;
    unique case ({wr_acc, rd_acc})
      2'b10:   used_nxt = usedw + CW'(1);
      2'b01:   used_nxt = usedw - CW'(1);
      default: used_nxt = usedw;
    endcase
  end

  // storage is never reset; flushed requests must not land
  always_ff @(posedge clock) begin
    if (wr_acc && !flush) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      usedw        <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + AW'(1);
        data_out <= mem[rd_ptr];
      end
      data_valid   <= rd_acc;
      usedw        <= used_nxt;
      full         <= (used_nxt == FULL_N);
      empty        <= (used_nxt == '0);
      almost_full  <= (used_nxt >= AF_N);
      almost_empty <= (used_nxt <= AE_N);
      overflow     <= overflow | (write & ~wr_acc);
      underflow    <= underflow | (read & ~rd_acc);
    end
  end

endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 The module SHALL have parameter DEPTH, default 32, number of entries; it SHALL be a power of two and at least 4.
REQ-002 The module SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-003 The module SHALL have parameter AF_LEVEL, default DEPTH-2, the almost-full threshold in entries.
REQ-004 The module SHALL have parameter AE_LEVEL, default 2, the almost-empty threshold in entries.
REQ-005 The module SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The module SHALL have port clear, input, 1 bit: synchronous flush, active-high.
REQ-008 The module SHALL have port data_in, input, WIDTH bits: write data.
REQ-009 The module SHALL have port write, input, 1 bit: write request.
REQ-010 The module SHALL have port read, input, 1 bit: read request.
REQ-011 The module SHALL have port data_out, output, WIDTH bits: registered read data.
REQ-012 The module SHALL have port data_valid, output, 1 bit: data_out updated by an accepted read this cycle.
REQ-013 The module SHALL have ports full, empty, almost_full and almost_empty, each output, 1 bit: status flags.
REQ-014 The module SHALL have port usedw, output, $clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.
REQ-015 The module SHALL have ports overflow and underflow, each output, 1 bit: sticky error flags.

Function
REQ-016 Storage SHALL be an internal DEPTH x WIDTH dual-port array with independent write and read pointers, each $clog2(DEPTH) bits.
REQ-017 Storage contents SHALL NOT be reset or cleared.
REQ-018 A read SHALL be accepted (rd_acc) iff read=1 and empty=0.
REQ-019 A write SHALL be accepted (wr_acc) iff write=1 and either full=0 or rd_acc=1, so a write is accepted on a simultaneous read while full.
REQ-020 On wr_acc, data_in SHALL be stored at the write pointer, and the write pointer SHALL then increment modulo DEPTH.
REQ-021 On rd_acc, data_out SHALL load the entry at the read pointer on the same clock edge (1-cycle latency), the read pointer SHALL increment modulo DEPTH, and data_valid SHALL be 1 for the following cycle.
REQ-022 Without rd_acc, data_out SHALL hold its value and data_valid SHALL be 0.
REQ-023 When read and write are both requested while empty, the write SHALL be accepted and the read rejected; there SHALL be no write-to-read bypass.
REQ-024 usedw SHALL update each cycle as usedw + wr_acc - rd_acc; on simultaneous wr_acc and rd_acc it SHALL stay unchanged.
REQ-025 The status flags SHALL be registered and consistent with usedw in the same cycle: full = (usedw==DEPTH), empty = (usedw==0), almost_full = (usedw>=AF_LEVEL), almost_empty = (usedw<=AE_LEVEL).
REQ-026 overflow SHALL set to 1 on any cycle with write=1 and wr_acc=0, and SHALL hold until reset or clear.
REQ-027 underflow SHALL set to 1 on any cycle with read=1 and rd_acc=0, and SHALL hold until reset or clear.
REQ-028 clear=1 SHALL take the same action as reset (REQ-030) on the next edge, ignoring write and read that cycle; the discarded requests SHALL NOT set overflow or underflow.
REQ-029 Pointer wrap-around SHALL be transparent: data order SHALL be preserved across any number of wraps.

Reset
REQ-030 On reset=1 at a rising edge: both pointers SHALL be 0, usedw=0, empty=1, almost_empty=1, full=0, almost_full=0, data_out=0, data_valid=0, overflow=0, underflow=0.
REQ-031 reset SHALL have priority over clear, write and read.
REQ-032 Reset asserted mid-operation SHALL discard all stored entries; the first read after release SHALL be rejected, with underflow set.

Verification
REQ-033 Fill/drain: DEPTH=32, WIDTH=8; write 0x00..0x1F on 32 consecutive cycles, then read 32 times -> full=1 and usedw=32 after the 32nd write; almost_full=1 from usedw=30; data_out sequence 0x00..0x1F, each one cycle after its read; empty=1 at the end.
REQ-034 Overflow/underflow: while full, write 0xAA without read -> write rejected, overflow=1 and sticky, usedw stays 32; read while empty -> underflow=1 and data_out unchanged.
REQ-035 Simultaneous access: when full, write 0x55 and read together -> both accepted, usedw stays 32, no overflow; when empty, write and read together -> usedw=1, underflow=1, data_valid=0.
REQ-036 Wrap-around: run 100 cycles of continuous write+read at steady occupancy 5 -> output stream equals input stream delayed by 5 accepted reads; no flag errors.
REQ-037 Clear/reset mid-operation: with usedw=10 and overflow=1, assert clear together with write -> next cycle usedw=0, empty=1, overflow=0, and the write is not stored; repeat with reset and get identical results.
